itag_inv_sequencer: RTL and testbench



---
 rtl/itag_inv_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_itag_inv_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itag_inv_sequencer.sv
// itag_inv_sequencer: owns I-cache tag port B; queued invalidations,
// optional fence.i walk (ITAG_FLUSH_EN), refill always wins the port.
// Ports: inv_* queue/handshake, flush_* walk control, fill_* refill,
// tb_* tag bank port B (write side out, one-cycle-late read side in).
module itag_inv_sequencer #(
  parameter int  WAYS            = 2,
  parameter int  LINES           = 512,
  parameter int  SUB_LINE_ADDR_W = 2,
  parameter int  TAG_W           = 20,
  parameter int  INV_FIFO_DEPTH  = 4,
  localparam int LINE_ADDR_W     = $clog2(LINES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inv_valid,
  input  logic [31:0]            inv_addr,
  output logic                   inv_ready,
  output logic                   inv_done,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   flush_done,
  input  logic                   fill_update,
  input  logic [WAYS-1:0]        fill_way,
  input  logic [31:0]            fill_addr,
  output logic                   tb_en,
  output logic [WAYS-1:0]        tb_wen,
  output logic [LINE_ADDR_W-1:0] tb_line_addr,
  output logic                   tb_wdata_valid,
  output logic [TAG_W-1:0]       tb_wdata_tag,
  input  logic [WAYS-1:0]        tb_rd_valid,
  input  logic [WAYS*TAG_W-1:0]  tb_rd_tag
);

  localparam int PW   = $clog2(INV_FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int LOFS = 2 + SUB_LINE_ADDR_W;
  localparam int TOFS = LOFS + LINE_ADDR_W;
  localparam int AW   = TOFS + TAG_W;

  typedef enum logic [1:0] {
    IDLE, INV_READ, INV_WRITE, FLUSH
  } state_e;

  function automatic logic [LINE_ADDR_W-1:0]
    line_of(input logic [31:0] a);
    return a[LOFS +: LINE_ADDR_W];
  endfunction

  // Tag field may run past bit 31; those bits read as 0.
  function automatic logic [TAG_W-1:0]
    tag_of(input logic [31:0] a);
    logic [AW-1:0] x;
    x = AW'(a);
    return x[TOFS +: TAG_W];
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   fifo_q [INV_FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty;
  logic          push, pop;
  logic [31:0]   head;
  logic [WAYS-1:0] hit;
  logic          go_flush;
  logic          walk_end;

  assign full      = cnt_q == CW'(INV_FIFO_DEPTH);
  assign empty     = cnt_q == '0;
  assign inv_ready = !full;
  assign push      = inv_valid && !full;
  assign pop       = inv_done;
  assign head      = fifo_q[rptr_q];

  always_comb begin
    hit = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit[i] = tb_rd_valid[i] &&
        (tb_rd_tag[i*TAG_W +: TAG_W] == tag_of(head));
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= inv_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

`ifdef ITAG_FLUSH_EN
  logic [LINE_ADDR_W-1:0] fcnt_q, fcnt_d;
  logic                   pend_q, pend_d;
  logic                   last;

  assign last     = fcnt_q == LINE_ADDR_W'(LINES - 1);
  assign go_flush = flush_req || pend_q;
  // A fill cycle or a restart request must not end the walk.
  assign walk_end = !fill_update && !flush_req && last;
  assign flush_done = (state_q == FLUSH) && walk_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      pend_q <= pend_d;
    end
  end
`else
  logic fdone_q;

  assign go_flush   = 1'b0;
  assign walk_end   = 1'b1;
  assign flush_done = fdone_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fdone_q <= 1'b0;
    else        fdone_q <= flush_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Retiring with more work queued skips IDLE so entries
  // issue every two cycles; a push this cycle counts too.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_flush)             state_d = FLUSH;
        else if (!empty || push)  state_d = INV_READ;
      end
      INV_READ: begin
        if (!fill_update) state_d = INV_WRITE;
      end
      INV_WRITE: begin
        if (fill_update)   state_d = INV_READ;
        else if (go_flush) state_d = FLUSH;
        else if (cnt_q > CW'(1) || push)
                           state_d = INV_READ;
        else               state_d = IDLE;
      end
      FLUSH: begin
        if (walk_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ITAG_FLUSH_EN
    fcnt_d = fcnt_q;
    pend_d = pend_q;
    if (state_q == FLUSH) begin
      if (flush_req)        fcnt_d = '0;
      else if (!fill_update)
        fcnt_d = last ? '0 : fcnt_q + LINE_ADDR_W'(1);
    end
    if (flush_req && (state_q == INV_READ ||
                      state_q == INV_WRITE))
      pend_d = 1'b1;
    if (state_d == FLUSH) pend_d = 1'b0;
`endif
  end

  always_comb begin
    tb_en          = 1'b0;
    tb_wen         = '0;
    tb_line_addr   = '0;
    tb_wdata_valid = 1'b0;
    tb_wdata_tag   = '0;
    inv_done       = 1'b0;
    flush_busy     = 1'b0;
    if (fill_update) begin
      tb_en          = 1'b1;
      tb_wen         = fill_way;
      tb_line_addr   = line_of(fill_addr);
      tb_wdata_valid = 1'b1;
      tb_wdata_tag   = tag_of(fill_addr);
    end else begin
      case (state_q)
        INV_READ: begin
          tb_en        = 1'b1;
          tb_line_addr = line_of(head);
        end
        INV_WRITE: begin
          tb_en        = 1'b1;
          tb_wen       = hit;
          tb_line_addr = line_of(head);
          inv_done     = 1'b1;
        end
`ifdef ITAG_FLUSH_EN
        FLUSH: begin
          tb_en        = 1'b1;
          tb_wen       = '1;
          tb_line_addr = fcnt_q;
        end
`endif
        default: ;
      endcase
    end
`ifdef ITAG_FLUSH_EN
    flush_busy = state_q == FLUSH;
`endif
  end

  logic unused_ok;
  assign unused_ok = ^{fill_addr, head};

endmodule

// File: tb/tb_itag_inv_sequencer.sv
// tb_itag_inv_sequencer: directed + random bench with a tag bank
// model and an address-level invalidation scoreboard.
module tb_itag_inv_sequencer;

  localparam int WAYS  = 2;
  localparam int LINES = 8;
  localparam int LAW   = 3;
  localparam int TAG_W = 25;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  inv_valid = 1'b0;
  logic [31:0]           inv_addr = '0;
  logic                  inv_ready, inv_done;
  logic                  flush_req = 1'b0;
  logic                  flush_busy, flush_done;
  logic                  fill_update = 1'b0;
  logic [WAYS-1:0]       fill_way = '0;
  logic [31:0]           fill_addr = '0;
  logic                  tb_en;
  logic [WAYS-1:0]       tb_wen;
  logic [LAW-1:0]        tb_line_addr;
  logic                  tb_wdata_valid;
  logic [TAG_W-1:0]      tb_wdata_tag;
  logic [WAYS-1:0]       tb_rd_valid = '0;
  logic [WAYS*TAG_W-1:0] tb_rd_tag = '0;

  always #5 clk = ~clk;

  itag_inv_sequencer #(
    .WAYS(WAYS), .LINES(LINES), .SUB_LINE_ADDR_W(2),
    .TAG_W(TAG_W), .INV_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .inv_ready(inv_ready), .inv_done(inv_done),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done),
    .fill_update(fill_update), .fill_way(fill_way),
    .fill_addr(fill_addr),
    .tb_en(tb_en), .tb_wen(tb_wen),
    .tb_line_addr(tb_line_addr),
    .tb_wdata_valid(tb_wdata_valid),
    .tb_wdata_tag(tb_wdata_tag),
    .tb_rd_valid(tb_rd_valid), .tb_rd_tag(tb_rd_tag)
  );

  int checks = 0;
  int errors = 0;

  // tag bank contents (driven by DUT port B) and reference copy
  bit               bv [WAYS][LINES];
  logic [TAG_W-1:0] bt [WAYS][LINES];
  bit               rv [WAYS][LINES];
  logic [TAG_W-1:0] rt [WAYS][LINES];
  logic [31:0]      q [$];

  logic             cap_en, cap_wv;
  logic [WAYS-1:0]  cap_wen;
  logic [LAW-1:0]   cap_line;
  logic [TAG_W-1:0] cap_wt;

  function automatic logic [LAW-1:0] lof(input logic [31:0] a);
    return LAW'((a / 16) % LINES);
  endfunction

  function automatic logic [TAG_W-1:0] tof(input logic [31:0] a);
    return TAG_W'(a / 128);
  endfunction

  function automatic logic [31:0] mkaddr(input int t, input int l,
                                         input int o);
    return 32'(t * 128 + l * 16 + o);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setmem(input int w, input int l, input bit v,
                        input logic [TAG_W-1:0] t);
    bv[w][l] = v; bt[w][l] = t;
    rv[w][l] = v; rt[w][l] = t;
  endtask

  task automatic randmem();
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++)
        setmem(w, l, 1'($urandom % 2),
               TAG_W'(32'h24 + $urandom % 2));
  endtask

  // Negedge: capture port B and run the scoreboard.
  task automatic nedge();
    logic [31:0]     a;
    logic [WAYS-1:0] h;
    @(negedge clk);
    cap_en = tb_en; cap_wen = tb_wen; cap_line = tb_line_addr;
    cap_wv = tb_wdata_valid; cap_wt = tb_wdata_tag;
    if (rst_n) begin
      if (fill_update) begin
        chk("fill_en", tb_en, 1);
        chk("fill_wen", tb_wen, fill_way);
        chk("fill_line", tb_line_addr, lof(fill_addr));
        chk("fill_wv", tb_wdata_valid, 1);
        chk("fill_tag", tb_wdata_tag, tof(fill_addr));
        chk("fill_no_done", inv_done, 0);
        for (int w = 0; w < WAYS; w++)
          if (fill_way[w]) begin
            rv[w][lof(fill_addr)] = 1'b1;
            rt[w][lof(fill_addr)] = tof(fill_addr);
          end
      end
      if (inv_done) begin
        chk("sb_q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          a = q.pop_front();
          h = '0;
          for (int w = 0; w < WAYS; w++)
            if (rv[w][lof(a)] && rt[w][lof(a)] == tof(a)) begin
              h[w] = 1'b1;
              rv[w][lof(a)] = 1'b0;
            end
          chk("sb_inv_line", tb_line_addr, lof(a));
          chk("sb_inv_wen", tb_wen, h);
          chk("sb_inv_wv", tb_wdata_valid, 0);
        end
      end
      if (inv_valid && inv_ready) q.push_back(inv_addr);
    end
  endtask

  // Posedge+1: tag bank reads old contents, then writes.
  task automatic pedge();
    @(posedge clk);
    #1;
    if (cap_en) begin
      for (int w = 0; w < WAYS; w++) begin
        tb_rd_valid[w] = bv[w][cap_line];
        tb_rd_tag[w*TAG_W +: TAG_W] = bt[w][cap_line];
      end
      for (int w = 0; w < WAYS; w++)
        if (cap_wen[w]) begin
          bv[w][cap_line] = cap_wv;
          bt[w][cap_line] = cap_wt;
        end
    end
  endtask

  task automatic cyc();
    nedge();
    pedge();
  endtask

  int  dones, done_c, acc_c, nb, nv, seen;
  bit  stop;

  initial begin
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++) setmem(w, l, 0, '0);
    cap_en = 0; cap_wen = '0; cap_line = '0;
    cap_wv = 0; cap_wt = '0;

    // reset state
    nedge();
    chk("rst_ready", inv_ready, 1);
    chk("rst_en", tb_en, 0);
    chk("rst_wen", tb_wen, 0);
    chk("rst_wv", tb_wdata_valid, 0);
    chk("rst_wtag", tb_wdata_tag, 0);
    chk("rst_done", inv_done, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_fdone", flush_done, 0);
    pedge();
    rst_n = 1'b1;
    cyc();

    // invalidation hit in way 1
    setmem(1, 3, 1, 'h24);
    setmem(0, 3, 1, 'h99);
    inv_valid = 1; inv_addr = 32'h0000_1234;
    nedge();
    chk("hit_t0_en", tb_en, 0);
    pedge();
    inv_valid = 0;
    nedge();
    chk("hit_rd_en", tb_en, 1);
    chk("hit_rd_wen", tb_wen, 0);
    chk("hit_rd_line", tb_line_addr, 3);
    chk("hit_rd_done", inv_done, 0);
    pedge();
    nedge();
    chk("hit_wr_wen", tb_wen, 2'b10);
    chk("hit_wr_done", inv_done, 1);
    chk("hit_wr_line", tb_line_addr, 3);
    pedge();
    nedge();
    chk("hit_post_en", tb_en, 0);
    chk("hit_post_done", inv_done, 0);
    pedge();
    chk("hit_bank_w1", bv[1][3], 0);
    chk("hit_bank_w0", bv[0][3], 1);

    // invalidation miss: still retires
    setmem(1, 3, 1, 'h25);
    inv_valid = 1; inv_addr = 32'h0000_1234;
    cyc();
    inv_valid = 0;
    cyc();
    nedge();
    chk("miss_wen", tb_wen, 0);
    chk("miss_done", inv_done, 1);
    pedge();
    nedge();
    chk("miss_empty_en", tb_en, 0);
    pedge();
    nedge();
    chk("miss_empty_en2", tb_en, 0);
    pedge();
    chk("miss_bank_w1", bv[1][3], 1);

    // fill collides with INV_WRITE
    setmem(1, 3, 1, 'h24);
    setmem(0, 3, 0, '0);
    inv_valid = 1; inv_addr = 32'h0000_1234;
    cyc();
    inv_valid = 0;
    cyc();
    fill_update = 1; fill_way = 2'b01;
    fill_addr = 32'h0000_0530;
    nedge();
    chk("col_wen", tb_wen, 2'b01);
    chk("col_tag", tb_wdata_tag, 'hA);
    chk("col_done", inv_done, 0);
    pedge();
    fill_update = 0;
    nedge();
    chk("col_retry_en", tb_en, 1);
    chk("col_retry_wen", tb_wen, 0);
    chk("col_retry_done", inv_done, 0);
    pedge();
    nedge();
    chk("col_wr_wen", tb_wen, 2'b10);
    chk("col_wr_done", inv_done, 1);
    pedge();
    chk("col_fill_kept", bv[0][3], 1);

    // queue full: fills hold the sequencer in INV_READ
    fill_update = 1; fill_way = 2'b00; fill_addr = '0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      inv_valid = 1; inv_addr = mkaddr(nv + 1, nv, 0);
      nedge();
      chk("full_ready", inv_ready, i < 4);
      if (inv_ready) nv++;
      pedge();
    end
    chk("full_pushed", nv, 4);
    fill_update = 0;
    dones = 0; done_c = -1; acc_c = -1;
    for (int j = 0; j < 40 && dones < 5; j++) begin
      nedge();
      if (inv_done) begin
        dones++;
        if (done_c < 0) done_c = j;
      end
      if (inv_valid && inv_ready) acc_c = j;
      pedge();
      if (acc_c >= 0) inv_valid = 0;
    end
    chk("full_all_retired", dones, 5);
    chk("full_fifth_held", acc_c - done_c, 1);

`ifdef ITAG_FLUSH_EN
    // plain flush walk
    randmem();
    flush_req = 1;
    nedge();
    chk("fl_t0_busy", flush_busy, 0);
    pedge();
    flush_req = 0;
    for (int i = 0; i < LINES; i++) begin
      nedge();
      chk("fl_busy", flush_busy, 1);
      chk("fl_line", tb_line_addr, i);
      chk("fl_wen", tb_wen, 2'b11);
      chk("fl_wv", tb_wdata_valid, 0);
      chk("fl_done", flush_done, i == LINES - 1);
      pedge();
    end
    nedge();
    chk("fl_after_busy", flush_busy, 0);
    chk("fl_after_done", flush_done, 0);
    pedge();
    nv = 0;
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++) nv += bv[w][l];
    chk("fl_all_invalid", nv, 0);

    // restart at line 4
    flush_req = 1;
    cyc();
    flush_req = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) flush_req = 1;
      nedge();
      chk("flr_line", tb_line_addr, i);
      chk("flr_done", flush_done, 0);
      pedge();
    end
    flush_req = 0;
    for (int i = 0; i < LINES; i++) begin
      nedge();
      chk("flr2_line", tb_line_addr, i);
      chk("flr2_done", flush_done, i == LINES - 1);
      pedge();
    end

    // fill at an already-walked line survives, walk stretches
    randmem();
    flush_req = 1;
    cyc();
    flush_req = 0;
    cyc();
    fill_update = 1; fill_way = 2'b01;
    fill_addr = 32'h0000_0F00;
    nedge();
    chk("flf_busy", flush_busy, 1);
    pedge();
    fill_update = 0;
    nb = 2; seen = 0;
    for (int j = 0; j < 20; j++) begin
      nedge();
      stop = !flush_busy;
      if (!stop) nb++;
      if (flush_done) seen++;
      pedge();
      if (stop) break;
    end
    chk("flf_len", nb, LINES + 1);
    chk("flf_done_once", seen, 1);
    nv = 0;
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++) nv += bv[w][l];
    chk("flf_valid_cnt", nv, 1);
    chk("flf_fill_v", bv[0][0], 1);
    chk("flf_fill_t", bt[0][0], 'h1E);

    // reset during walk at counter 5
    randmem();
    flush_req = 1;
    cyc();
    flush_req = 0;
    for (int i = 0; i < 5; i++) cyc();
    nedge();
    chk("frst_pre_line", tb_line_addr, 5);
    #2 rst_n = 0;
    #1;
    chk("frst_en", tb_en, 0);
    chk("frst_wen", tb_wen, 0);
    chk("frst_busy", flush_busy, 0);
    chk("frst_done", flush_done, 0);
    chk("frst_ready", inv_ready, 1);
    pedge();
    pedge();
    rst_n = 1;
    q.delete();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      nedge();
      if (flush_done || flush_busy || tb_en) seen++;
      pedge();
    end
    chk("frst_quiet", seen, 0);
    chk("frst_ready2", inv_ready, 1);
`else
    // no walker: done pulses the cycle after the request
    flush_req = 1;
    nedge();
    chk("nf_t0_done", flush_done, 0);
    chk("nf_t0_busy", flush_busy, 0);
    pedge();
    flush_req = 0;
    nedge();
    chk("nf_t1_done", flush_done, 1);
    chk("nf_t1_busy", flush_busy, 0);
    chk("nf_t1_en", tb_en, 0);
    pedge();
    nedge();
    chk("nf_t2_done", flush_done, 0);
    pedge();
    flush_req = 1;
    cyc();
    flush_req = 0;
    rst_n = 0;
    #1;
    chk("nf_rst_done", flush_done, 0);
    chk("nf_rst_ready", inv_ready, 1);
    pedge();
    rst_n = 1;
    q.delete();
    nedge();
    chk("nf_rel_done", flush_done, 0);
    pedge();
`endif

    // random invalidations and fills vs reference
    randmem();
    for (int i = 0; i < 400; i++) begin
      inv_valid = ($urandom % 2) == 0;
      inv_addr = mkaddr(32'h24 + $urandom % 2,
                        $urandom % LINES, $urandom % 16);
      fill_update = ($urandom % 4) == 0;
      fill_way = WAYS'(1 << ($urandom % WAYS));
      fill_addr = mkaddr(32'h24 + $urandom % 2,
                         $urandom % LINES, $urandom % 16);
      cyc();
    end
    inv_valid = 0; fill_update = 0;
    for (int j = 0; j < 40 && q.size() != 0; j++) cyc();
    chk("rnd_drained", q.size(), 0);
    cyc();
    nv = 0;
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++)
        if (bv[w][l] !== rv[w][l] ||
            (rv[w][l] && bt[w][l] !== rt[w][l])) nv++;
    chk("rnd_bank_vs_ref", nv, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
